// File: rtl/ahb_bus_arbiter_if.sv
// Request/grant bundle between the AHB masters and the bus arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface ahb_bus_arbiter_if #(
    parameter int unsigned NO_OF_MASTERS = 4,
    parameter int unsigned HMASTER_WIDTH = 4
);
    logic [NO_OF_MASTERS-1:0] hbusreq;
    logic [NO_OF_MASTERS-1:0] hlock;
    logic [1:0]               htrans;
    logic [2:0]               hburst;
    logic                     hready;
    logic [NO_OF_MASTERS-1:0] hgrant;
    logic [HMASTER_WIDTH-1:0] hmaster;
    logic [HMASTER_WIDTH-1:0] hmasterData;
    logic                     hmastlock;

    modport master (
        output hbusreq, hlock, htrans, hburst, hready,
        input  hgrant, hmaster, hmasterData, hmastlock
    );

    modport slave (
        input  hbusreq, hlock, htrans, hburst, hready,
        output hgrant, hmaster, hmasterData, hmastlock
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter that keeps ownership fixed across fixed-length bursts,
// INCR bursts and locked sequences, and drives address/data-phase master IDs.
module ahb_bus_arbiter #(
    parameter int unsigned NO_OF_MASTERS  = 4,
    parameter int unsigned HMASTER_WIDTH  = 4,
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input logic              hclk,
    input logic              hreset,
    ahb_bus_arbiter_if.slave bus
);

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;
    localparam logic [2:0] BurstIncr   = 3'b001;

    typedef enum logic [1:0] {StOpen, StBurst, StUndef, StLocked} state_e;

    state_e                   state_q, state_d;
    logic [3:0]               beats_q, beats_d;
    logic                     lock_q, lock_d;
    logic [NO_OF_MASTERS-1:0] hgrant_q, hgrant_d;
    logic [HMASTER_WIDTH-1:0] ptr_q, ptr_d;
    logic [HMASTER_WIDTH-1:0] hmaster_q, hmaster_d;
    logic [HMASTER_WIDTH-1:0] hmdata_q, hmdata_d;

    logic [NO_OF_MASTERS-1:0] own_sel;
    logic                     own_req;
    logic                     own_lock;
    logic [HMASTER_WIDTH-1:0] grant_idx;
    logic [HMASTER_WIDTH-1:0] win_idx;
    logic                     win_found;
    logic [3:0]               burst_len;

    always_comb begin
        own_sel = '0;
        for (int unsigned i = 0; i < NO_OF_MASTERS; i++) begin
            own_sel[i] = (hmaster_q == HMASTER_WIDTH'(i));
        end
    end

    assign own_req  = |(bus.hbusreq & own_sel);
    assign own_lock = |(bus.hlock & own_sel);

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < NO_OF_MASTERS; i++) begin
            if (hgrant_q[i]) grant_idx = HMASTER_WIDTH'(i);
        end
    end

    // Round-robin search starting one past the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = HMASTER_WIDTH'(DEFAULT_MASTER);
        for (int unsigned k = 1; k <= NO_OF_MASTERS; k++) begin
            for (int unsigned i = 0; i < NO_OF_MASTERS; i++) begin
                if (!win_found && bus.hbusreq[i] &&
                    (i == (32'(ptr_q) + k) % NO_OF_MASTERS)) begin
                    win_found = 1'b1;
                    win_idx   = HMASTER_WIDTH'(i);
                end
            end
        end
    end

    always_comb begin
        case (bus.hburst)
            3'b010, 3'b011: burst_len = 4'd3;
            3'b100, 3'b101: burst_len = 4'd7;
            3'b110, 3'b111: burst_len = 4'd15;
            default:        burst_len = 4'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        beats_d   = beats_q;
        lock_d    = lock_q;
        hgrant_d  = hgrant_q;
        ptr_d     = ptr_q;
        hmaster_d = hmaster_q;
        hmdata_d  = hmdata_q;

        if (bus.hready) begin
            hmaster_d = grant_idx;
            hmdata_d  = hmaster_q;

            case (state_q)
                StBurst: begin
                    if (bus.htrans == TransSeq) begin
                        if (beats_q != 4'd0) beats_d = beats_q - 4'd1;
                        if (beats_q <= 4'd1) state_d = StOpen;
                    end else if (bus.htrans == TransIdle) begin
                        beats_d = 4'd0;
                        state_d = StOpen;
                    end
                end
                StUndef: begin
                    if (bus.htrans == TransIdle || !own_req) state_d = StOpen;
                end
                StLocked: begin
                    if (bus.htrans == TransSeq && beats_q != 4'd0) beats_d = beats_q - 4'd1;
                    if (!own_lock &&
                        (bus.htrans == TransIdle || bus.htrans == TransNonseq)) begin
                        state_d = StOpen;
                        lock_d  = 1'b0;
                    end
                end
                default: ;
            endcase

            // A NONSEQ always starts a fresh sequence, whatever was in flight.
            if (bus.htrans == TransNonseq) begin
                beats_d = burst_len;
                lock_d  = own_lock;
                if (own_lock)                    state_d = StLocked;
                else if (burst_len != 4'd0)      state_d = StBurst;
                else if (bus.hburst == BurstIncr) state_d = StUndef;
                else                             state_d = StOpen;
            end

            // Rearbitrate only when the bus will be open after this beat.
            if (state_d == StOpen) begin
                hgrant_d = NO_OF_MASTERS'(1) << win_idx;
                if (win_found) ptr_d = win_idx;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q   <= StOpen;
            beats_q   <= 4'd0;
            lock_q    <= 1'b0;
            hgrant_q  <= NO_OF_MASTERS'(1) << DEFAULT_MASTER;
            ptr_q     <= HMASTER_WIDTH'(DEFAULT_MASTER);
            hmaster_q <= HMASTER_WIDTH'(DEFAULT_MASTER);
            hmdata_q  <= HMASTER_WIDTH'(DEFAULT_MASTER);
        end else begin
            state_q   <= state_d;
            beats_q   <= beats_d;
            lock_q    <= lock_d;
            hgrant_q  <= hgrant_d;
            ptr_q     <= ptr_d;
            hmaster_q <= hmaster_d;
            hmdata_q  <= hmdata_d;
        end
    end

    assign bus.hgrant      = hgrant_q;
    assign bus.hmaster     = hmaster_q;
    assign bus.hmasterData = hmdata_q;
    assign bus.hmastlock   = lock_q;

    a_grant_onehot: assert property (@(posedge hclk) disable iff (hreset)
        $onehot(hgrant_q));

    a_master_range: assert property (@(posedge hclk) disable iff (hreset)
        32'(hmaster_q) < NO_OF_MASTERS);

    a_grant_hold: assert property (@(posedge hclk) disable iff (hreset)
        (state_d == StBurst || state_d == StLocked) |-> (hgrant_d == hgrant_q));

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: stimulus pushes expected outputs into a
// queue, a monitor pops and compares them one cycle later.
module tb_ahb_bus_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4;

    localparam logic [1:0] TI = 2'b00;
    localparam logic [1:0] TB = 2'b01;
    localparam logic [1:0] TN = 2'b10;
    localparam logic [1:0] TS = 2'b11;

    localparam logic [2:0] SGL = 3'b000;
    localparam logic [2:0] I4  = 3'b011;
    localparam logic [2:0] I8  = 3'b101;
    localparam logic [2:0] I16 = 3'b111;

    logic hclk   = 1'b0;
    logic hreset = 1'b1;

    ahb_bus_arbiter_if #(.NO_OF_MASTERS(N), .HMASTER_WIDTH(W)) bus ();

    ahb_bus_arbiter #(
        .NO_OF_MASTERS (N),
        .HMASTER_WIDTH (W),
        .DEFAULT_MASTER(0)
    ) dut (
        .hclk  (hclk),
        .hreset(hreset),
        .bus   (bus)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        int         id;
        logic [3:0] g;
        logic [3:0] m;
        logic [3:0] d;
        logic       l;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input int id, input logic [3:0] act,
                       input logic [3:0] req);
        if (act !== req) begin
            n_bad++;
            $display("FAIL vec %0d %s: got %b, want %b", id, nm, act, req);
        end
    endtask

    // Apply one cycle of inputs and queue the outputs expected after the next edge.
    task automatic vec(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                       input logic [3:0] eg, input logic [3:0] em, input logic [3:0] ed,
                       input logic el);
        exp_t e;
        @(negedge hclk);
        hreset          = rst;
        bus.hbusreq     = req;
        bus.hlock       = lock;
        bus.htrans      = tr;
        bus.hburst      = bu;
        bus.hready      = rdy;
        e.id            = n_vec;
        e.g             = eg;
        e.m             = em;
        e.d             = ed;
        e.l             = el;
        exp_q.push_back(e);
        n_vec++;
    endtask

    always @(posedge hclk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("hgrant", e.id, bus.hgrant, e.g);
            chk("hmaster", e.id, bus.hmaster, e.m);
            chk("hmasterData", e.id, bus.hmasterData, e.d);
            chk("hmastlock", e.id, {3'b000, bus.hmastlock}, {3'b000, e.l});
        end
    end

    initial begin
        bus.hbusreq = '0;
        bus.hlock   = '0;
        bus.htrans  = TI;
        bus.hburst  = SGL;
        bus.hready  = 1'b1;

        // Reset, then idle bus parks on master 0, also across a wait state.
        vec(1, 4'b0000, 4'b0000, TI, SGL, 1, 4'b0001, 0, 0, 0);
        for (int i = 0; i < 3; i++) vec(0, 4'b0000, 4'b0000, TI, SGL, 1, 4'b0001, 0, 0, 0);
        vec(0, 4'b0000, 4'b0000, TI, SGL, 0, 4'b0001, 0, 0, 0);

        // Masters 1 and 2 alternate on SINGLE transfers.
        vec(0, 4'b0110, 4'b0000, TN, SGL, 1, 4'b0010, 0, 0, 0);
        vec(0, 4'b0110, 4'b0000, TN, SGL, 1, 4'b0100, 1, 0, 0);
        vec(0, 4'b0110, 4'b0000, TN, SGL, 1, 4'b0010, 2, 1, 0);
        vec(0, 4'b0110, 4'b0000, TN, SGL, 1, 4'b0100, 1, 2, 0);
        vec(0, 4'b0110, 4'b0000, TN, SGL, 1, 4'b0010, 2, 1, 0);

        // Master 1 INCR4 with two BUSY beats and a 3-cycle wait while master 2 waits.
        vec(0, 4'b0010, 4'b0000, TI, SGL, 1, 4'b0010, 1, 2, 0);
        vec(0, 4'b0010, 4'b0000, TI, SGL, 1, 4'b0010, 1, 1, 0);
        vec(0, 4'b0110, 4'b0000, TN, I4, 1, 4'b0010, 1, 1, 0);
        vec(0, 4'b0110, 4'b0000, TS, I4, 1, 4'b0010, 1, 1, 0);
        vec(0, 4'b0110, 4'b0000, TB, I4, 1, 4'b0010, 1, 1, 0);
        vec(0, 4'b0110, 4'b0000, TB, I4, 1, 4'b0010, 1, 1, 0);
        vec(0, 4'b0110, 4'b0000, TS, I4, 1, 4'b0010, 1, 1, 0);
        for (int i = 0; i < 3; i++) vec(0, 4'b0110, 4'b0000, TS, I4, 0, 4'b0010, 1, 1, 0);
        vec(0, 4'b0110, 4'b0000, TS, I4, 1, 4'b0100, 1, 1, 0);
        vec(0, 4'b0100, 4'b0000, TI, SGL, 1, 4'b0100, 2, 1, 0);
        vec(0, 4'b0100, 4'b0000, TI, SGL, 1, 4'b0100, 2, 2, 0);

        // Master 3 locked sequence of 5 transfers with everyone requesting.
        vec(0, 4'b1000, 4'b0000, TI, SGL, 1, 4'b1000, 2, 2, 0);
        vec(0, 4'b1000, 4'b0000, TI, SGL, 1, 4'b1000, 3, 2, 0);
        vec(0, 4'b1000, 4'b0000, TI, SGL, 1, 4'b1000, 3, 3, 0);
        for (int i = 0; i < 5; i++) vec(0, 4'b1111, 4'b1000, TN, SGL, 1, 4'b1000, 3, 3, 1);
        vec(0, 4'b1111, 4'b0000, TI, SGL, 1, 4'b0001, 3, 3, 0);
        vec(0, 4'b1111, 4'b0000, TI, SGL, 1, 4'b0010, 0, 3, 0);

        // Master 0 INCR8 aborted by IDLE after 3 beats; master 2 takes over.
        vec(0, 4'b0001, 4'b0000, TI, SGL, 1, 4'b0001, 1, 0, 0);
        vec(0, 4'b0001, 4'b0000, TI, SGL, 1, 4'b0001, 0, 1, 0);
        vec(0, 4'b0101, 4'b0000, TN, I8, 1, 4'b0001, 0, 0, 0);
        vec(0, 4'b0101, 4'b0000, TS, I8, 1, 4'b0001, 0, 0, 0);
        vec(0, 4'b0101, 4'b0000, TS, I8, 1, 4'b0001, 0, 0, 0);
        vec(0, 4'b0101, 4'b0000, TI, SGL, 1, 4'b0100, 0, 0, 0);
        vec(0, 4'b0100, 4'b0000, TI, SGL, 1, 4'b0100, 2, 0, 0);

        // Master 2 INCR16, reset with 9 beats left, then pointer restarts at 0.
        vec(0, 4'b0111, 4'b0000, TN, I16, 1, 4'b0100, 2, 2, 0);
        for (int i = 0; i < 6; i++) vec(0, 4'b0111, 4'b0000, TS, I16, 1, 4'b0100, 2, 2, 0);
        vec(1, 4'b0111, 4'b0000, TS, I16, 1, 4'b0001, 0, 0, 0);
        vec(0, 4'b0101, 4'b0000, TI, SGL, 1, 4'b0100, 0, 0, 0);
        vec(0, 4'b0101, 4'b0000, TI, SGL, 1, 4'b0001, 2, 0, 0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge hclk);
        #2;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected responses never checked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
